// File: rtl/jailbreak_rom_pkg.sv
// Shared FSM type and ROM map constants for the Jailbreak ROM download path.
// The region bases are shared with the selector so both agree on the map.
package jailbreak_rom_pkg;

   localparam int unsigned ADDR_W = 25;
   localparam int unsigned SUM_W  = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CHECK,
      S_HOLD,
      S_RUN,
      S_FAIL
   } dl_state_e;

   localparam logic [ADDR_W-1:0] ROM_SIZE_C = 25'h24240;

   localparam logic [ADDR_W-1:0] EP1 = 25'h00000;
   localparam logic [ADDR_W-1:0] EP2 = 25'h04000;
   localparam logic [ADDR_W-1:0] EP3 = 25'h08000;
   localparam logic [ADDR_W-1:0] EP4 = 25'h0C000;
   localparam logic [ADDR_W-1:0] EP5 = 25'h10000;
   localparam logic [ADDR_W-1:0] EP6 = 25'h14000;
   localparam logic [ADDR_W-1:0] EP7 = 25'h18000;
   localparam logic [ADDR_W-1:0] EP8 = 25'h1C000;
   localparam logic [ADDR_W-1:0] EP9 = 25'h20000;
   localparam logic [ADDR_W-1:0] SL  = 25'h24000;
   localparam logic [ADDR_W-1:0] TL  = 25'h24100;
   localparam logic [ADDR_W-1:0] CP1 = 25'h24200;
   localparam logic [ADDR_W-1:0] CP2 = 25'h24220;

endpackage

// File: rtl/jailbreak_rom_download.sv
// Qualifies data_io ROM download bytes onto a registered write bus, counts and
// checksums the image, and holds the game core in reset until a clean image lands.
module jailbreak_rom_download
   import jailbreak_rom_pkg::*;
#(
   parameter logic [ADDR_W-1:0] ROM_SIZE    = ROM_SIZE_C,
   parameter logic [7:0]        ROM_INDEX   = 8'd0,
   parameter int unsigned       HOLD_CYCLES = 16
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              IOCTL_DOWNLOAD,
   input  logic [7:0]        IOCTL_INDEX,
   input  logic              IOCTL_WR,
   input  logic [ADDR_W-1:0] IOCTL_ADDR,
   input  logic [7:0]        IOCTL_DOUT,
   output logic              DL_WR,
   output logic [ADDR_W-1:0] DL_ADDR,
   output logic [7:0]        DL_DATA,
   output logic [ADDR_W-1:0] BYTE_COUNT,
   output logic [SUM_W-1:0]  CHECKSUM,
   output logic              ROM_READY,
   output logic              CORE_RESET,
   output logic              LOAD_ERR
);

   localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   dl_state_e           state;
   dl_state_e           state_nxt;
   logic [HOLD_W-1:0]   hold_cnt;
   logic                gap;
   logic                idx_match;
   logic                enter;
   logic                accept;
   logic                fwd;

   assign idx_match = (IOCTL_INDEX == ROM_INDEX);
   assign enter     = IOCTL_DOWNLOAD && idx_match && (state != S_LOAD);
   assign accept    = IOCTL_DOWNLOAD && IOCTL_WR && idx_match && (state == S_LOAD);
   assign fwd       = accept && (IOCTL_ADDR < ROM_SIZE);

   always_ff @(posedge CLK) begin
      if (RESET) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // A matching download restarts the load from any state.
   always_comb begin
      state_nxt = state;
      if (enter) begin
         state_nxt = S_LOAD;
      end else begin
         case (state)
            S_LOAD:  if (!IOCTL_DOWNLOAD) state_nxt = S_CHECK;
            S_CHECK: state_nxt = ((BYTE_COUNT == ROM_SIZE) && !gap) ? S_HOLD : S_FAIL;
            S_HOLD:  if (hold_cnt == '0) state_nxt = S_RUN;
            default: state_nxt = state;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         hold_cnt <= '0;
      end else if ((state == S_CHECK) && (state_nxt == S_HOLD)) begin
         hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
      end else if ((state == S_HOLD) && (hold_cnt != '0)) begin
         hold_cnt <= hold_cnt - HOLD_W'(1);
      end
   end

   // Write bus, counters and status flags; status follows the state one cycle later.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         DL_WR      <= 1'b0;
         DL_ADDR    <= '0;
         DL_DATA    <= '0;
         BYTE_COUNT <= '0;
         CHECKSUM   <= '0;
         gap        <= 1'b0;
         ROM_READY  <= 1'b0;
         CORE_RESET <= 1'b1;
         LOAD_ERR   <= 1'b0;
      end else begin
         DL_WR <= fwd;
         if (fwd) begin
            DL_ADDR <= IOCTL_ADDR;
            DL_DATA <= IOCTL_DOUT;
         end
         if (enter) begin
            BYTE_COUNT <= '0;
            CHECKSUM   <= '0;
            gap        <= 1'b0;
         end else if (fwd) begin
            BYTE_COUNT <= BYTE_COUNT + ADDR_W'(1);
            CHECKSUM   <= CHECKSUM + SUM_W'(IOCTL_DOUT);
            if (IOCTL_ADDR != BYTE_COUNT) gap <= 1'b1;
         end
         ROM_READY  <= !enter && (state == S_RUN);
         CORE_RESET <= enter || (state != S_RUN);
         LOAD_ERR   <= !enter && (state == S_FAIL);
      end
   end

endmodule

// File: tb/tb_jailbreak_rom_download.sv
// Randomized bench for jailbreak_rom_download against a byte-list reference model.
module tb_jailbreak_rom_download;

   localparam logic [24:0] SIZE = 25'h300;
   localparam int unsigned HOLD = 16;
   localparam logic [7:0]  RIDX = 8'd0;

   logic        clk = 1'b0;
   logic        rst;
   logic        dl;
   logic [7:0]  idx;
   logic        wr;
   logic [24:0] addr;
   logic [7:0]  dout;
   logic        dl_wr;
   logic [24:0] dl_addr;
   logic [7:0]  dl_data;
   logic [24:0] byte_count;
   logic [15:0] checksum;
   logic        rom_ready;
   logic        core_reset;
   logic        load_err;

   jailbreak_rom_download #(
      .ROM_SIZE   (SIZE),
      .ROM_INDEX  (RIDX),
      .HOLD_CYCLES(HOLD)
   ) dut (
      .CLK           (clk),
      .RESET         (rst),
      .IOCTL_DOWNLOAD(dl),
      .IOCTL_INDEX   (idx),
      .IOCTL_WR      (wr),
      .IOCTL_ADDR    (addr),
      .IOCTL_DOUT    (dout),
      .DL_WR         (dl_wr),
      .DL_ADDR       (dl_addr),
      .DL_DATA       (dl_data),
      .BYTE_COUNT    (byte_count),
      .CHECKSUM      (checksum),
      .ROM_READY     (rom_ready),
      .CORE_RESET    (core_reset),
      .LOAD_ERR      (load_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [24:0] a;
      logic [7:0]  d;
   } wr_t;

   // Reference model: the list of bytes the image should contain, in arrival order.
   wr_t         expq[$];
   wr_t         e_item;
   int          m_count;
   logic [15:0] m_sum;
   bit          m_gap;
   int          pulses;
   logic [7:0]  idx_r;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && dl_wr) begin
         pulses++;
         if (expq.size() == 0) begin
            chk("dl_wr_unexpected", 32'd1, 32'd0);
         end else begin
            e_item = expq.pop_front();
            chk("dl_addr", 32'(dl_addr), 32'(e_item.a));
            chk("dl_data", 32'(dl_data), 32'(e_item.d));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_dl(input logic [7:0] i);
      dl     = 1'b1;
      idx    = i;
      idx_r  = i;
      pulses = 0;
      if (i == RIDX) begin
         m_count = 0;
         m_sum   = '0;
         m_gap   = 1'b0;
         @(posedge clk);
         @(negedge clk);
         chk("entry_err",   32'(load_err),   32'd0);
         chk("entry_ready", 32'(rom_ready),  32'd0);
         chk("entry_crst",  32'(core_reset), 32'd1);
         chk("entry_count", 32'(byte_count), 32'd0);
         chk("entry_sum",   32'(checksum),   32'd0);
         @(posedge clk);
         #1;
      end else begin
         tick(1);
      end
      tick($urandom_range(0, 2));
   endtask

   task automatic send(input logic [24:0] a, input logic [7:0] d);
      wr   = 1'b1;
      addr = a;
      dout = d;
      if (idx_r == RIDX && a < SIZE) begin
         if (a != 25'(m_count)) m_gap = 1'b1;
         m_count++;
         m_sum = m_sum + 16'(d);
         expq.push_back('{a: a, d: d});
      end
      tick(1);
      wr = 1'b0;
      tick($urandom_range(0, 2));
   endtask

   // Drops the download and checks the image verdict and its timing.
   task automatic end_dl(input bit strobe_at_end);
      bit good;
      dl = 1'b0;
      if (strobe_at_end) begin
         wr   = 1'b1;
         addr = 25'(m_count);
         dout = 8'hA5;
      end
      @(posedge clk);
      #1;
      wr = 1'b0;
      @(negedge clk);
      chk("count",  32'(byte_count), 32'(m_count));
      chk("sum",    32'(checksum),   32'(m_sum));
      chk("pulses", 32'(pulses),     32'(m_count));
      chk("drain",  32'(expq.size()), 32'd0);
      good = (m_count == int'(SIZE)) && !m_gap;
      if (good) begin
         repeat (HOLD + 1) @(posedge clk);
         @(negedge clk);
         chk("ready_early", 32'(rom_ready),  32'd0);
         chk("crst_early",  32'(core_reset), 32'd1);
         @(posedge clk);
         @(negedge clk);
         chk("ready_rise", 32'(rom_ready),  32'd1);
         chk("crst_fall",  32'(core_reset), 32'd0);
         chk("good_err",   32'(load_err),   32'd0);
      end else begin
         @(posedge clk);
         @(negedge clk);
         chk("err_early", 32'(load_err), 32'd0);
         @(posedge clk);
         @(negedge clk);
         chk("err_rise",  32'(load_err),   32'd1);
         chk("bad_ready", 32'(rom_ready),  32'd0);
         chk("bad_crst",  32'(core_reset), 32'd1);
         repeat (HOLD + 4) @(posedge clk);
         @(negedge clk);
         chk("err_sticky",  32'(load_err),   32'd1);
         chk("crst_sticky", 32'(core_reset), 32'd1);
         chk("ready_low",   32'(rom_ready),  32'd0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic seq_load(input int n, input bit strobe_at_end);
      start_dl(RIDX);
      for (int a = 0; a < n; a++) send(25'(a), 8'($urandom));
      end_dl(strobe_at_end);
   endtask

   initial begin
      rst  = 1'b1;
      dl   = 1'b0;
      idx  = 8'd0;
      idx_r = 8'd0;
      wr   = 1'b0;
      addr = '0;
      dout = '0;
      m_count = 0;
      m_sum   = '0;
      m_gap   = 1'b0;
      pulses  = 0;
      tick(3);
      @(negedge clk);
      chk("rst_dl_wr", 32'(dl_wr),      32'd0);
      chk("rst_addr",  32'(dl_addr),    32'd0);
      chk("rst_data",  32'(dl_data),    32'd0);
      chk("rst_count", 32'(byte_count), 32'd0);
      chk("rst_sum",   32'(checksum),   32'd0);
      chk("rst_ready", 32'(rom_ready),  32'd0);
      chk("rst_crst",  32'(core_reset), 32'd1);
      chk("rst_err",   32'(load_err),   32'd0);
      rst = 1'b0;
      tick(2);

      // Full image, plus a strobe on the falling download that must be ignored.
      seq_load(int'(SIZE), 1'b1);

      // Short image.
      seq_load(int'(SIZE) / 3, 1'b0);

      // Good reload straight out of FAIL.
      seq_load(int'(SIZE), 1'b0);

      // Address gap, with an out-of-range byte sent last.
      begin
         int k;
         k = int'($urandom_range(1, int'(SIZE) - 2));
         start_dl(RIDX);
         for (int a = 0; a < int'(SIZE); a++)
            if (a != k) send(25'(a), 8'($urandom));
         send(SIZE, 8'($urandom));
         end_dl(1'b0);
      end

      // Oversize image: the tail beyond the image is dropped silently.
      seq_load(int'(SIZE) + 'h40, 1'b0);

      // Other index while running changes nothing.
      start_dl(8'd1);
      for (int a = 0; a < 'h40; a++) send(25'(a), 8'($urandom));
      dl = 1'b0;
      tick(HOLD + 4);
      @(negedge clk);
      chk("oidx_pulses", 32'(pulses),     32'd0);
      chk("oidx_ready",  32'(rom_ready),  32'd1);
      chk("oidx_crst",   32'(core_reset), 32'd0);
      chk("oidx_count",  32'(byte_count), 32'(m_count));
      chk("oidx_err",    32'(load_err),   32'd0);
      @(posedge clk);
      #1;

      // Reset in the middle of a load.
      start_dl(RIDX);
      for (int a = 0; a < 'hA0; a++) send(25'(a), 8'($urandom));
      rst = 1'b1;
      dl  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("mrst_count", 32'(byte_count), 32'd0);
      chk("mrst_sum",   32'(checksum),   32'd0);
      chk("mrst_crst",  32'(core_reset), 32'd1);
      chk("mrst_ready", 32'(rom_ready),  32'd0);
      chk("mrst_dl_wr", 32'(dl_wr),      32'd0);
      expq.delete();
      rst = 1'b0;
      tick(2);

      // Clean load after the reset.
      seq_load(int'(SIZE), 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
